// File: rtl/rf_pkg.sv
// Shared widths and grant encoding for the register-file write arbiter.
package rf_pkg;

   localparam int RF_ADDR_WIDTH = 5;
   localparam int RF_DATA_WIDTH = 32;

   localparam logic GNT_A = 1'b0;
   localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/rf_arb_grant.sv
// Grant selection for the two writeback requesters, plus the round-robin
// pointer and the B starvation counter that steer it.
module rf_arb_grant
   import rf_pkg::*;
#(
   parameter int RR_MODE    = 0,
   parameter int STARVE_MAX = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic a_valid,
   input  logic b_valid,
   output logic gnt_sel,
   output logic a_ready,
   output logic b_ready,
   output logic b_starved
);

   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          ptr_q, ptr_d;
   logic          starved_q;
   logic          starved;
   logic          xfer;

   always_comb begin
      starved = (RR_MODE == 0) && (cnt_q == STARVE_LIM);
      gnt_sel = GNT_A;
      if (a_valid && b_valid) begin
         if (RR_MODE != 0) begin
            gnt_sel = ptr_q;
         end else if (starved) begin
            gnt_sel = GNT_B;
         end
      end else if (b_valid) begin
         gnt_sel = GNT_B;
      end

      a_ready = !reset && a_valid && (gnt_sel == GNT_A);
      b_ready = !reset && b_valid && (gnt_sel == GNT_B);
      xfer    = a_ready || b_ready;

      // Pointer always favours whoever did not win the last transfer.
      ptr_d = ptr_q;
      if (xfer) begin
         ptr_d = ~gnt_sel;
      end

      cnt_d = cnt_q;
      if (RR_MODE == 0) begin
         if (b_ready) begin
            cnt_d = '0;
         end else if (b_valid && !starved) begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q     <= '0;
         ptr_q     <= GNT_A;
         starved_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         starved_q <= (RR_MODE == 0) && (cnt_d == STARVE_LIM);
      end
   end

   assign b_starved = starved_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file write port between ALU (A) and load (B) writeback,
// with a registered output stage feeding regWrite/writeReg/writeData directly.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int RR_MODE    = 0,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic [ADDR_WIDTH-1:0] a_reg,
   input  logic [DATA_WIDTH-1:0] a_data,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [ADDR_WIDTH-1:0] b_reg,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic                  regWrite,
   output logic [ADDR_WIDTH-1:0] writeReg,
   output logic [DATA_WIDTH-1:0] writeData,
   output logic                  b_starved
);

   logic                  gnt_sel;
   logic [ADDR_WIDTH-1:0] sel_reg;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  wr_en;

   logic                  regWrite_q;
   logic [ADDR_WIDTH-1:0] writeReg_q;
   logic [DATA_WIDTH-1:0] writeData_q;

   rf_arb_grant #(
      .RR_MODE    (RR_MODE),
      .STARVE_MAX (STARVE_MAX)
   ) u_grant (
      .clock     (clock),
      .reset     (reset),
      .a_valid   (a_valid),
      .b_valid   (b_valid),
      .gnt_sel   (gnt_sel),
      .a_ready   (a_ready),
      .b_ready   (b_ready),
      .b_starved (b_starved)
   );

   // Writes to x0 are accepted upstream but never reach the register file,
   // and leave the last issued index/data visible.
   always_comb begin
      sel_reg  = (gnt_sel == GNT_B) ? b_reg  : a_reg;
      sel_data = (gnt_sel == GNT_B) ? b_data : a_data;
      wr_en    = (a_ready || b_ready) && (sel_reg != '0);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         regWrite_q  <= 1'b0;
         writeReg_q  <= '0;
         writeData_q <= '0;
      end else begin
         regWrite_q <= wr_en;
         if (wr_en) begin
            writeReg_q  <= sel_reg;
            writeData_q <= sel_data;
         end
      end
   end

   assign regWrite  = regWrite_q;
   assign writeReg  = writeReg_q;
   assign writeData = writeData_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench: one fixed-priority and one round-robin arbiter share the
// same directed stimulus; expected readies/outputs are queued and checked by monitors.
module tb_rf_write_arbiter;

   logic        clk;
   logic        rst;
   logic        av, bv;
   logic [4:0]  ar, br;
   logic [31:0] ad, bd;

   logic        a_rdy0, b_rdy0, rw0, st0;
   logic [4:0]  wr0;
   logic [31:0] wd0;
   logic        a_rdy1, b_rdy1, rw1, st1;
   logic [4:0]  wr1;
   logic [31:0] wd1;

   typedef struct {
      logic a0, b0, a1, b1;
   } rdy_t;

   typedef struct {
      logic        rw0;
      logic [4:0]  wr0;
      logic [31:0] wd0;
      logic        st0;
      logic        rw1;
      logic [4:0]  wr1;
      logic [31:0] wd1;
      logic        st1;
   } out_t;

   rdy_t rdy_q[$];
   out_t out_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_cyc    = 0;

   localparam logic [31:0] DA = 32'hAAAA_0001;
   localparam logic [31:0] DB = 32'hBBBB_0002;
   localparam logic [31:0] DE = 32'hDEAD_BEEF;
   localparam logic [31:0] D7 = 32'h7777_7777;

   rf_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .RR_MODE(0), .STARVE_MAX(4)) dut0 (
      .clock(clk), .reset(rst),
      .a_valid(av), .a_ready(a_rdy0), .a_reg(ar), .a_data(ad),
      .b_valid(bv), .b_ready(b_rdy0), .b_reg(br), .b_data(bd),
      .regWrite(rw0), .writeReg(wr0), .writeData(wd0), .b_starved(st0)
   );

   rf_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .RR_MODE(1), .STARVE_MAX(4)) dut1 (
      .clock(clk), .reset(rst),
      .a_valid(av), .a_ready(a_rdy1), .a_reg(ar), .a_data(ad),
      .b_valid(bv), .b_ready(b_rdy1), .b_reg(br), .b_data(bd),
      .regWrite(rw1), .writeReg(wr1), .writeData(wd1), .b_starved(st1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic rdy_t mk_rdy(input logic a0, input logic b0, input logic a1, input logic b1);
      rdy_t r;
      r.a0 = a0; r.b0 = b0; r.a1 = a1; r.b1 = b1;
      return r;
   endfunction

   function automatic out_t mk_out(input logic rw_0, input logic [4:0] wr_0, input logic [31:0] wd_0,
                                   input logic st_0, input logic rw_1, input logic [4:0] wr_1,
                                   input logic [31:0] wd_1, input logic st_1);
      out_t o;
      o.rw0 = rw_0; o.wr0 = wr_0; o.wd0 = wd_0; o.st0 = st_0;
      o.rw1 = rw_1; o.wr1 = wr_1; o.wd1 = wd_1; o.st1 = st_1;
      return o;
   endfunction

   task automatic step(input logic r, input logic a_v, input logic [4:0] a_r, input logic [31:0] a_d,
                       input logic b_v, input logic [4:0] b_r, input logic [31:0] b_d,
                       input rdy_t er, input out_t eo);
      @(posedge clk);
      #2;
      rst = r; av = a_v; ar = a_r; ad = a_d; bv = b_v; br = b_r; bd = b_d;
      rdy_q.push_back(er);
      out_q.push_back(eo);
   endtask

   // Readies are combinational: check mid-cycle against this cycle's stimulus.
   always @(negedge clk) begin
      rdy_t r;
      if (rdy_q.size() > 0) begin
         r = rdy_q.pop_front();
         chk("fp_a_ready", {31'd0, a_rdy0}, {31'd0, r.a0});
         chk("fp_b_ready", {31'd0, b_rdy0}, {31'd0, r.b0});
         chk("rr_a_ready", {31'd0, a_rdy1}, {31'd0, r.a1});
         chk("rr_b_ready", {31'd0, b_rdy1}, {31'd0, r.b1});
      end
   end

   // Registered outputs: check just after the edge that consumed the stimulus.
   always @(posedge clk) begin
      out_t o;
      #1;
      if (out_q.size() > 0) begin
         o = out_q.pop_front();
         n_cyc++;
         $display("cyc %0d: fp rw=%0b wr=%0d wd=%h st=%0b | rr rw=%0b wr=%0d wd=%h st=%0b",
                  n_cyc, rw0, wr0, wd0, st0, rw1, wr1, wd1, st1);
         chk("fp_regWrite",  {31'd0, rw0}, {31'd0, o.rw0});
         chk("fp_writeReg",  {27'd0, wr0}, {27'd0, o.wr0});
         chk("fp_writeData", wd0, o.wd0);
         chk("fp_b_starved", {31'd0, st0}, {31'd0, o.st0});
         chk("rr_regWrite",  {31'd0, rw1}, {31'd0, o.rw1});
         chk("rr_writeReg",  {27'd0, wr1}, {27'd0, o.wr1});
         chk("rr_writeData", wd1, o.wd1);
         chk("rr_b_starved", {31'd0, st1}, {31'd0, o.st1});
      end
   end

   // Both valid on every cycle; fixed priority runs A,A,A,A,B and round-robin A,B.
   task automatic contested(input int n);
      logic fa, ra, s0;
      for (int i = 0; i < n; i++) begin
         fa = (i % 5) != 4;
         ra = (i % 2) == 0;
         s0 = (i % 5) == 3;
         step(1'b0, 1'b1, 5'd1, DA, 1'b1, 5'd2, DB,
              mk_rdy(fa, !fa, ra, !ra),
              mk_out(1'b1, fa ? 5'd1 : 5'd2, fa ? DA : DB, s0,
                     1'b1, ra ? 5'd1 : 5'd2, ra ? DA : DB, 1'b0));
      end
   endtask

   initial begin
      rst = 1'b1; av = 1'b0; bv = 1'b0; ar = '0; br = '0; ad = '0; bd = '0;

      // Reset, including a valid request that must not be accepted.
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
           mk_rdy(0, 0, 0, 0), mk_out(0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0, 0));
      step(1'b1, 1'b1, 5'd3, 32'h1111_1111, 1'b0, 5'd0, 32'd0,
           mk_rdy(0, 0, 0, 0), mk_out(0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0, 0));

      repeat (5)
         step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
              mk_rdy(0, 0, 0, 0), mk_out(0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0, 0));

      // Single A write, then idle hold.
      step(1'b0, 1'b1, 5'd5, DE, 1'b0, 5'd0, 32'd0,
           mk_rdy(1, 0, 1, 0), mk_out(1, 5'd5, DE, 0, 1, 5'd5, DE, 0));
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
           mk_rdy(0, 0, 0, 0), mk_out(0, 5'd5, DE, 0, 0, 5'd5, DE, 0));

      // B write to x0: accepted but dropped, outputs hold.
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234_5678,
           mk_rdy(0, 1, 0, 1), mk_out(0, 5'd5, DE, 0, 0, 5'd5, DE, 0));

      // Two full starvation periods plus three cycles (fp counter ends at 3).
      contested(13);

      // A write to reg 7, then reset on the following edge.
      step(1'b0, 1'b1, 5'd7, D7, 1'b0, 5'd0, 32'd0,
           mk_rdy(1, 0, 1, 0), mk_out(1, 5'd7, D7, 0, 1, 5'd7, D7, 0));
      step(1'b1, 1'b1, 5'd7, D7, 1'b0, 5'd0, 32'd0,
           mk_rdy(0, 0, 0, 0), mk_out(0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0, 0));

      // Counter and pointer must restart from their reset values.
      contested(5);

      @(posedge clk);
      #2;
      rst = 1'b0; av = 1'b0; bv = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      chk("queues_drained", rdy_q.size() + out_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
